// File: rtl/mop_pkg.sv
// Shared types and default sizing for the multi-operand accumulator controller.
package mop_pkg;

    localparam int unsigned DefW      = 16;
    localparam int unsigned DefNOps   = 8;
    localparam int unsigned DefAddLat = 1;

    typedef enum logic [2:0] {
        StIdle,
        StAccWait,
        StEval,
        StCapt,
        StDone
    } mop_state_e;

endpackage

// File: rtl/mop_eval_timer.sv
// Counts the shared adder's evaluation latency; done_o is high in the last EVAL cycle.
module mop_eval_timer
    import mop_pkg::*;
#(
    parameter int unsigned ADD_LAT = DefAddLat
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic done_o
);

    localparam int unsigned TW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    logic          busy_q, busy_d;
    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = TW'(ADD_LAT - 1);
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - TW'(1);
            end
        end
    end

    assign done_o = busy_q && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/mop_acc_ctrl.sv
// Sums a group of operands through an external shared adder, one operand per adder pass.
// Optional group counter output stat_groups is built when MOP_ACC_STATS_EN is defined.
module mop_acc_ctrl
    import mop_pkg::*;
#(
    parameter int unsigned W       = DefW,
    parameter int unsigned N_OPS   = DefNOps,
    parameter int unsigned ADD_LAT = DefAddLat,
    localparam int unsigned CW     = $clog2(N_OPS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic            in_last,
    output logic [W-1:0]    add_a,
    output logic [W-1:0]    add_b,
    output logic            add_cin,
    input  logic [W:0]      add_sum,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W+CW-1:0] out_sum,
    output logic [CW:0]     out_count,
    output logic            out_err
`ifdef MOP_ACC_STATS_EN
    ,
    output logic [31:0]     stat_groups
`endif
);

    localparam logic [CW:0] CntMax = (CW + 1)'(N_OPS);

    mop_state_e      state_q, state_d;
    logic [W-1:0]    acc_lo_q, acc_lo_d;
    logic [CW-1:0]   acc_hi_q, acc_hi_d;
    logic [CW:0]     cnt_q, cnt_d, cnt_inc;
    logic            last_q, last_d;
    logic            err_q, err_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [W+CW-1:0] out_sum_q, out_sum_d;
    logic [CW:0]     out_count_q, out_count_d;
    logic            out_err_q, out_err_d;
    logic            accept, timer_start, timer_done;

    assign accept  = in_valid && in_ready_q;
    assign cnt_inc = cnt_q + (CW + 1)'(1);

    mop_eval_timer #(
        .ADD_LAT (ADD_LAT)
    ) u_eval_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (timer_start),
        .done_o  (timer_done)
    );

    always_comb begin
        state_d     = state_q;
        acc_lo_d    = acc_lo_q;
        acc_hi_d    = acc_hi_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        err_d       = err_q;
        opnd_d      = opnd_q;
        timer_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    acc_lo_d = in_data;
                    acc_hi_d = '0;
                    cnt_d    = (CW + 1)'(1);
                    last_d   = in_last;
                    err_d    = 1'b0;
                    state_d  = in_last ? StDone : StAccWait;
                end
            end
            StAccWait: begin
                if (accept) begin
                    opnd_d      = in_data;
                    cnt_d       = cnt_inc;
                    // Reaching N_OPS closes the group even without in_last.
                    last_d      = in_last || (cnt_inc == CntMax);
                    err_d       = !in_last && (cnt_inc == CntMax);
                    timer_start = 1'b1;
                    state_d     = StEval;
                end
            end
            StEval: begin
                if (timer_done) begin
                    state_d = StCapt;
                end
            end
            StCapt: begin
                acc_lo_d = add_sum[W-1:0];
                acc_hi_d = acc_hi_q + CW'(add_sum[W]);
                state_d  = last_q ? StDone : StAccWait;
            end
            StDone: begin
                if (out_ready) begin
                    acc_lo_d = '0;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    last_d   = 1'b0;
                    err_d    = 1'b0;
                    opnd_d   = '0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from next-state values so they change with the state.
        in_ready_d  = (state_d == StIdle) || (state_d == StAccWait);
        out_valid_d = (state_d == StDone);
        out_sum_d   = out_valid_d ? {acc_hi_d, acc_lo_d} : '0;
        out_count_d = out_valid_d ? cnt_d : '0;
        out_err_d   = out_valid_d && err_d;
    end

`ifdef MOP_ACC_STATS_EN
    logic [31:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if ((state_q == StDone) && out_ready) begin
            stat_d = stat_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_groups = stat_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_lo_q    <= '0;
            acc_hi_q    <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            opnd_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_lo_q    <= acc_lo_d;
            acc_hi_q    <= acc_hi_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            err_q       <= err_d;
            opnd_q      <= opnd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign add_a     = acc_lo_q;
    assign add_b     = opnd_q;
    assign add_cin   = 1'b0;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_err   = out_err_q;

endmodule
